// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered N-bit ripple-borrow full subtractor
//
// Computes {bo, d} = a - b - c (unsigned) and registers it with one cycle latency.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  operands valid this cycle
//   a, b      minuend / subtrahend, WIDTH bits
//   c         borrow-in (weight 2^0)
//   out_valid registered result valid
//   d         registered difference
//   bo        registered borrow-out
//   bv        registered per-bit borrow vector (bv[WIDTH-1] == bo)
//   zero      registered flag: d == 0 and bo == 0
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic [WIDTH-1:0] bv,
  output logic             zero
);

  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] bv_next;
  logic             zero_next;
  logic             borrow;

  // Ripple the borrow through a scalar so the chain stays a single
  // combinational path without a self-referencing vector.
  always_comb begin
    d_next  = '0;
    bv_next = '0;
    borrow  = c;
    for (int i = 0; i < WIDTH; i++) begin
      d_next[i]  = a[i] ^ b[i] ^ borrow;
      bv_next[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
      borrow     = bv_next[i];
    end
    zero_next = (d_next == '0) && !bv_next[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      bo        <= 1'b0;
      bv        <= '0;
      zero      <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      d         <= d_next;
      bo        <= bv_next[WIDTH-1];
      bv        <= bv_next;
      zero      <= zero_next;
    end else begin
      // Result registers hold; only the qualifier drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - directed self-checking bench for full_subtractor
module tb_full_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        c;
  logic        a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        ov1, bo1, z1;
  logic        d1, bv1;
  logic        ov8, bo8, z8;
  logic [7:0]  d8, bv8;
  logic        ov16, bo16, z16;
  logic [15:0] d16, bv16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .c(c),
    .out_valid(ov1), .d(d1), .bo(bo1), .bv(bv1), .zero(z1)
  );

  full_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .c(c),
    .out_valid(ov8), .d(d8), .bo(bo8), .bv(bv8), .zero(z8)
  );

  full_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .c(c),
    .out_valid(ov16), .d(d16), .bo(bo16), .bv(bv16), .zero(z16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic r, input logic v, input logic cin,
                      input logic x1, input logic y1,
                      input logic [7:0] x8, input logic [7:0] y8,
                      input logic [15:0] x16, input logic [15:0] y16);
    @(negedge clk);
    rst_n = r; in_valid = v; c = cin;
    a1 = x1; b1 = y1; a8 = x8; b8 = y8; a16 = x16; b16 = y16;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  exp_d1, exp_bo1, exp_z1;
    logic [2:0]  abc;
    logic [16:0] ref17;
    exp_d1  = 8'b1001_0110;
    exp_bo1 = 8'b1000_1110;
    exp_z1  = 8'b0110_0001;

    rst_n = 1'b0; in_valid = 1'b1; c = 1'b0;
    a1 = 1'b1; b1 = 1'b0; a8 = 8'h01; b8 = 8'h00; a16 = 16'h1; b16 = 16'h0;

    // Reset with in_valid asserted: outputs stay cleared.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 16'h1, 16'h0);
      check("rst_ov1", ov1, 0);
      check("rst_d1",  d1, 0);
      check("rst_bo1", bo1, 0);
      check("rst_bv1", bv1, 0);
      check("rst_z1",  z1, 0);
      check("rst_ov8", ov8, 0);
      check("rst_d8",  d8, 0);
      check("rst_bv8", bv8, 0);
      check("rst_z8",  z8, 0);
    end

    // WIDTH=1 truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      step(1'b1, 1'b1, abc[0], abc[2], abc[1], 8'h00, 8'h00, 16'h0, 16'h0);
      check("w1_ov", ov1, 1);
      check("w1_d",  d1,  exp_d1[i]);
      check("w1_bo", bo1, exp_bo1[i]);
      check("w1_bv", bv1, exp_bo1[i]);
      check("w1_z",  z1,  exp_z1[i]);
    end

    // WIDTH=8 wrap and exact-zero.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'h0, 16'h0);
    check("w8_wrap_d",  d8, 8'hFF);
    check("w8_wrap_bo", bo8, 1);
    check("w8_wrap_bv", bv8, 8'hFF);
    check("w8_wrap_z",  z8, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h0F, 16'h0, 16'h0);
    check("w8_zero_d",  d8, 8'h00);
    check("w8_zero_bo", bo8, 0);
    check("w8_zero_bv", bv8, 8'h0F);
    check("w8_zero_z",  z8, 1);

    // Hold: one valid op, then idle cycles with random operands.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h03, 16'h0, 16'h0);
    check("hold_ov0", ov8, 1);
    check("hold_d0",  d8, 8'h02);
    check("hold_bv0", bv8, 8'h02);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
      check("hold_ov", ov8, 0);
      check("hold_d",  d8, 8'h02);
      check("hold_bo", bo8, 0);
      check("hold_bv", bv8, 8'h02);
      check("hold_z",  z8, 0);
    end

    // Mid-stream reset, then immediate result on release.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h01, 16'h0, 16'h0);
    check("ms_pre_d", d8, 8'h1F);
    check("ms_pre_ov", ov8, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 16'h0, 16'h0);
    check("ms_rst_ov", ov8, 0);
    check("ms_rst_d",  d8, 0);
    check("ms_rst_bv", bv8, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 8'h09, 16'h0, 16'h0);
    check("ms_rel_ov", ov8, 1);
    check("ms_rel_d",  d8, 8'hFE);
    check("ms_rel_bo", bo8, 1);

    // WIDTH=16 directed corners.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 16'h1234, 16'h0234);
    check("w16_a_d", d16, 16'h1000);
    check("w16_a_bo", bo16, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 16'h0000, 16'hFFFF);
    check("w16_b_d", d16, 16'h0000);
    check("w16_b_bo", bo16, 1);
    check("w16_b_z", z16, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 16'hFFFF, 16'hFFFF);
    check("w16_c_d", d16, 16'hFFFF);
    check("w16_c_bo", bo16, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 16'h8000, 16'h7FFF);
    check("w16_d_d", d16, 16'h0000);
    check("w16_d_z", z16, 1);

    // WIDTH=16 random ops against an arithmetic reference.
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref17 = {1'b0, ra} - {1'b0, rb} - {16'h0, rc};
      step(1'b1, 1'b1, rc, 1'b0, 1'b0, 8'h0, 8'h0, ra, rb);
      check("w16_rnd", {ov16, bo16, d16}, {1'b1, ref17});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered N-bit full subtractor computing {bo, d} = a - b - c, where c is the borrow-in.
- With WIDTH=1 it is the classic single-bit full subtractor cell: difference d, borrow-out bo.
- Sits in datapath arithmetic as a building block for subtract/compare chains.
- One clock, synchronous active-low reset, one-cycle registered latency with a valid qualifier.

Parameters:
- WIDTH, default 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- c  input  1  borrow-in (weight 2^0)
- out_valid  output  1  registered result valid
- d  output  WIDTH  registered difference
- bo  output  1  registered borrow-out (1 when a < b + c, unsigned)
- bv  output  WIDTH  registered per-bit borrow vector; bv[i] is the borrow out of bit i (bv[WIDTH-1] equals bo)
- zero  output  1  registered flag, 1 when d == 0 and bo == 0

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state updates occur on the rising edge of clk.
- Per-bit cell, with borrow-in br[0] = c and br[i+1] = bv[i]:
  - d[i] = a[i] ^ b[i] ^ br[i]
  - bv[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])
- Ripple borrow chain is purely combinational inside one cycle. No pipelining between bits.
- Single-bit truth table (a b c -> d bo), must hold exactly for WIDTH=1:
  - 000->00, 001->11, 010->11, 011->01
  - 100->10, 101->00, 110->00, 111->11
- Arithmetic: {bo, d} equals (a - b - c) mod 2^(WIDTH+1), unsigned. Borrow-out wraps the result modulo 2^WIDTH.
- Reset (rst_n == 0 at a rising edge): out_valid=0, d=0, bo=0, bv=0, zero=0. Reset has priority over in_valid.
- Normal operation:
  - in_valid=1 at edge N: d, bo, bv, zero capture that cycle's result, and out_valid=1 after edge N (latency 1).
  - in_valid=0 at an edge: out_valid=0, and d/bo/bv/zero hold their previous values.
- Back-to-back in_valid: one result per cycle, full throughput, no stall, no backpressure.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on outputs.
- Reset deasserted mid-stream: the first edge with rst_n=1 and in_valid=1 produces a valid result immediately.
- No X propagation from unused inputs: when in_valid=0, a/b/c values are ignored.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=0, c=0 -> out_valid=0, d=0, bo=0, bv=0, zero=0 throughout.
- WIDTH=1 exhaustive: drive all 8 (a,b,c) combos in order 000..111, in_valid=1 each cycle -> one cycle later d/bo = 0/0, 1/1, 1/1, 0/1, 1/0, 0/0, 0/0, 1/1; zero=1 only for 000, 101, 110.
- WIDTH=8 wrap: a=0x00, b=0x01, c=0 -> d=0xFF, bo=1, bv=0xFF. Then a=0x10, b=0x0F, c=1 -> d=0x00, bo=0, zero=1.
- Hold behaviour: issue one valid op (a=5, b=3, c=0, WIDTH=8 -> d=0x02, bo=0), then in_valid=0 with random a/b/c -> out_valid=0, d stays 0x02.
- Mid-stream reset: stream valid ops, assert rst_n=0 for one edge -> outputs cleared next cycle. On release, next valid op appears after exactly 1 cycle.
- Randomized WIDTH=16: 1000 random valid ops vs reference model {bo,d}=a-b-c -> all match with 1-cycle latency.
